// File: rtl/qmem_sram_ctrl.sv
// qmem_sram_ctrl: single-clock QMEM slave driving an asynchronous SRAM.
// Each QMEM access is split into SDW-wide sub-accesses; sub-words with all-zero sel are skipped.
module qmem_sram_ctrl #(
  parameter int QAW = 32,
  parameter int QDW = 32,
  parameter int QSW = QDW/8,
  parameter int SAW = 18,
  parameter int SDW = 16,
  parameter int SSW = SDW/8,
  parameter int RWS = 1,
  parameter int WWS = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cs,
  input  logic           we,
  input  logic [QSW-1:0] sel,
  input  logic [QAW-1:0] adr,
  input  logic [QDW-1:0] dat_w,
  output logic [QDW-1:0] dat_r,
  output logic           ack,
  output logic           err,
  output logic [SAW-1:0] sram_adr,
  output logic           sram_ce_n,
  output logic           sram_we_n,
  output logic           sram_oe_n,
  output logic [SSW-1:0] sram_be_n,
  output logic [SDW-1:0] sram_dat_w,
  output logic           sram_dat_oe,
  input  logic [SDW-1:0] sram_dat_r
);
  localparam int R    = QDW / SDW;
  localparam int KW   = (R > 1) ? $clog2(R) : 1;
  localparam int LSSW = $clog2(SSW);
  localparam int HI   = SAW + LSSW;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RECOV, ST_ACK} state_t;

  state_t         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           we_q, we_d;
  logic [QSW-1:0] sel_q, sel_d;
  logic [SAW-1:0] wadr_q, wadr_d;
  logic [QDW-1:0] dat_q, dat_d;
  logic [QDW-1:0] dat_r_q, dat_r_d;
  logic           ack_q, ack_d;
  logic           err_q, err_d;
  logic [SAW-1:0] sram_adr_q, sram_adr_d;
  logic           ce_n_q, ce_n_d;
  logic           we_n_q, we_n_d;
  logic           oe_n_q, oe_n_d;
  logic [SSW-1:0] be_n_q, be_n_d;
  logic [SDW-1:0] sram_dat_w_q, sram_dat_w_d;
  logic           dat_oe_q, dat_oe_d;

  logic           we_s;
  logic [QSW-1:0] sel_s;
  logic [SAW-1:0] wadr_s;
  logic [QDW-1:0] dat_s;
  int unsigned    start, kk;
  logic           nxt_found;
  logic [KW-1:0]  nxt_idx;
  logic           do_sub, do_ack;
  logic           unused_adr;

  // Byte-offset bits below the SRAM word are not needed for addressing.
  assign unused_adr = ^(adr & QAW'(SSW - 1));

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    sel_d        = sel_q;
    wadr_d       = wadr_q;
    dat_d        = dat_q;
    dat_r_d      = dat_r_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    sram_adr_d   = sram_adr_q;
    ce_n_d       = ce_n_q;
    we_n_d       = we_n_q;
    oe_n_d       = oe_n_q;
    be_n_d       = be_n_q;
    sram_dat_w_d = sram_dat_w_q;
    dat_oe_d     = dat_oe_q;
    do_sub       = 1'b0;
    do_ack       = 1'b0;
    kk           = 32'(k_q);

    // Live inputs in IDLE, latched copies afterwards, so the next-sub-word search is shared.
    if (state_q == ST_IDLE) begin
      we_s   = we;
      sel_s  = sel;
      wadr_s = adr[HI-1:LSSW];
      dat_s  = dat_w;
      start  = 0;
    end else begin
      we_s   = we_q;
      sel_s  = sel_q;
      wadr_s = wadr_q;
      dat_s  = dat_q;
      start  = 32'(k_q) + 32'd1;
    end

    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int unsigned j = 0; j < R; j++) begin
      if (!nxt_found && j >= start && |sel_s[j*SSW +: SSW]) begin
        nxt_found = 1'b1;
        nxt_idx   = KW'(j);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (cs) begin
          dat_r_d = '0;
          if (|adr[QAW-1:HI]) begin
            err_d  = 1'b1;
            do_ack = 1'b1;
          end else if (sel == '0) begin
            do_ack = 1'b1;
          end else begin
            we_d   = we;
            sel_d  = sel;
            wadr_d = wadr_s;
            dat_d  = dat_w;
            do_sub = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == (we_q ? 4'(WWS) : 4'(RWS))) begin
          if (we_q) begin
            state_d = ST_RECOV;
            we_n_d  = 1'b1;
          end else begin
            for (int unsigned b = 0; b < SSW; b++)
              dat_r_d[kk*SDW + b*8 +: 8] = sel_q[kk*SSW + b] ? sram_dat_r[b*8 +: 8] : 8'h00;
            do_sub = nxt_found;
            do_ack = !nxt_found;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RECOV: begin
        do_sub = nxt_found;
        do_ack = !nxt_found;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (do_sub) begin
      state_d    = ST_ACCESS;
      k_d        = nxt_idx;
      cnt_d      = '0;
      ce_n_d     = 1'b0;
      we_n_d     = !we_s;
      oe_n_d     = we_s;
      dat_oe_d   = we_s;
      be_n_d     = ~sel_s[32'(nxt_idx)*SSW +: SSW];
      sram_adr_d = (wadr_s & ~SAW'(R - 1)) | SAW'(nxt_idx);
      if (we_s) sram_dat_w_d = dat_s[32'(nxt_idx)*SDW +: SDW];
    end
    if (do_ack) begin
      state_d  = ST_ACK;
      ack_d    = 1'b1;
      ce_n_d   = 1'b1;
      we_n_d   = 1'b1;
      oe_n_d   = 1'b1;
      be_n_d   = '1;
      dat_oe_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      wadr_q       <= '0;
      dat_q        <= '0;
      dat_r_q      <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      sram_adr_q   <= '0;
      ce_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      be_n_q       <= '1;
      sram_dat_w_q <= '0;
      dat_oe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      wadr_q       <= wadr_d;
      dat_q        <= dat_d;
      dat_r_q      <= dat_r_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      sram_adr_q   <= sram_adr_d;
      ce_n_q       <= ce_n_d;
      we_n_q       <= we_n_d;
      oe_n_q       <= oe_n_d;
      be_n_q       <= be_n_d;
      sram_dat_w_q <= sram_dat_w_d;
      dat_oe_q     <= dat_oe_d;
    end
  end

  assign dat_r       = dat_r_q;
  assign ack         = ack_q;
  assign err         = err_q;
  assign sram_adr    = sram_adr_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_be_n   = be_n_q;
  assign sram_dat_w  = sram_dat_w_q;
  assign sram_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_qmem_sram_ctrl.sv
// Bench for qmem_sram_ctrl: behavioural async SRAM, vector table with a scoreboard queue,
// plus hand-written reset, back-to-back and protocol sequences.
module tb_qmem_sram_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        cs, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w, dat_r;
  logic        ack, err;
  logic [17:0] sram_adr;
  logic        sram_ce_n, sram_we_n, sram_oe_n, sram_dat_oe;
  logic [1:0]  sram_be_n;
  logic [15:0] sram_dat_w, sram_dat_r;

  qmem_sram_ctrl #(.QAW(32), .QDW(32), .SAW(18), .SDW(16), .RWS(1), .WWS(1)) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .sel(sel), .adr(adr), .dat_w(dat_w),
    .dat_r(dat_r), .ack(ack), .err(err), .sram_adr(sram_adr), .sram_ce_n(sram_ce_n),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_be_n(sram_be_n),
    .sram_dat_w(sram_dat_w), .sram_dat_oe(sram_dat_oe), .sram_dat_r(sram_dat_r)
  );

  always #5 clk = ~clk;

  // SRAM model: word i initialised to {8'h5A, i}; 256 words, address wraps on the low 8 bits.
  logic [15:0] mem [0:255];
  int          ce_total = 0;
  int          viol = 0;
  logic [1:0]  last_be;
  logic [17:0] last_adr;

  assign sram_dat_r = (!sram_ce_n && !sram_oe_n) ? mem[sram_adr[7:0]] : 16'hffff;

  initial for (int i = 0; i < 256; i++) mem[i] = {8'h5A, 8'(i)};

  always @(negedge clk) begin
    if (!sram_ce_n) begin
      ce_total++;
      last_be  = sram_be_n;
      last_adr = sram_adr;
    end
    if (!sram_we_n) begin
      if (sram_ce_n || !sram_dat_oe || !sram_oe_n) viol++;
      else begin
        if (!sram_be_n[0]) mem[sram_adr[7:0]][7:0]  = sram_dat_w[7:0];
        if (!sram_be_n[1]) mem[sram_adr[7:0]][15:8] = sram_dat_w[15:8];
      end
    end
    if (!sram_oe_n && (sram_ce_n || sram_dat_oe)) viol++;
  end

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] exp_dat;
    logic        exp_err;
    int          exp_lat;
    logic [1:0]  exp_be;
    logic [17:0] exp_adr;
  } vec_t;

  vec_t vecs [17];
  vec_t sb [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // SRAM cycles with ce_n low: k*(RWS+1) for reads, k*(WWS+2) for writes, none for err/zero-sel.
  function automatic int exp_ce_of(input vec_t v);
    int k = 0;
    if (v.adr[31:19] != 0) return 0;
    for (int i = 0; i < 2; i++) if (v.sel[i*2 +: 2] != 2'b00) k++;
    return v.we ? k*3 : k*2;
  endfunction

  task automatic run(input vec_t v, input string tag);
    int   lat = 0;
    int   ce0;
    int   ece;
    vec_t e;
    @(negedge clk);
    cs = 1'b1; we = v.we; sel = v.sel; adr = v.adr; dat_w = v.dat_w;
    sb.push_back(v);
    ce0 = ce_total;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack && lat < 40);
    e   = sb.pop_front();
    ece = exp_ce_of(e);
    chk($sformatf("%s.lat", tag), lat, e.exp_lat);
    chk($sformatf("%s.err", tag), err, e.exp_err);
    chk($sformatf("%s.dat_r", tag), dat_r, e.exp_dat);
    chk($sformatf("%s.ce_cycles", tag), ce_total - ce0, ece);
    if (ece != 0) begin
      chk($sformatf("%s.be_n", tag), last_be, e.exp_be);
      chk($sformatf("%s.sram_adr", tag), last_adr, e.exp_adr);
    end
    @(negedge clk);
    cs = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("%s.ack_pulse", tag), ack, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          acks;
    logic [5:0]  pat;
    logic [15:0] mexp [10];
    int          midx [10];

    //           we    sel    adr            dat_w          exp_dat        err   lat be     adr
    vecs[0]  = '{1'b1, 4'hF, 32'h0000_0000, 32'hdeadbeef, 32'h0000_0000, 1'b0, 7, 2'b00, 18'h00001};
    vecs[1]  = '{1'b0, 4'hF, 32'h0000_0000, 32'h0,        32'hdeadbeef, 1'b0, 5, 2'b00, 18'h00001};
    vecs[2]  = '{1'b1, 4'h3, 32'h0000_0004, 32'h12345678, 32'h0000_0000, 1'b0, 4, 2'b00, 18'h00002};
    vecs[3]  = '{1'b0, 4'h3, 32'h0000_0004, 32'h0,        32'h0000_5678, 1'b0, 3, 2'b00, 18'h00002};
    vecs[4]  = '{1'b0, 4'h4, 32'h0000_0004, 32'h0,        32'h0003_0000, 1'b0, 3, 2'b10, 18'h00003};
    vecs[5]  = '{1'b0, 4'hF, 32'h0000_0004, 32'h0,        32'h5a03_5678, 1'b0, 5, 2'b00, 18'h00003};
    vecs[6]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,        32'h0000_0000, 1'b0, 1, 2'b11, 18'h00000};
    vecs[7]  = '{1'b0, 4'hF, 32'h0008_0000, 32'h0,        32'h0000_0000, 1'b1, 1, 2'b11, 18'h00000};
    vecs[8]  = '{1'b1, 4'h0, 32'hFFFF_FFFC, 32'h55555555, 32'h0000_0000, 1'b1, 1, 2'b11, 18'h00000};
    vecs[9]  = '{1'b0, 4'h6, 32'h0000_0000, 32'h0,        32'h00ad_be00, 1'b0, 5, 2'b10, 18'h00001};
    vecs[10] = '{1'b1, 4'hC, 32'h0000_0008, 32'hcafef00d, 32'h0000_0000, 1'b0, 4, 2'b00, 18'h00005};
    vecs[11] = '{1'b0, 4'hF, 32'h0000_0008, 32'h0,        32'hcafe_5a04, 1'b0, 5, 2'b00, 18'h00005};
    vecs[12] = '{1'b1, 4'h9, 32'h0000_000C, 32'haabbccdd, 32'h0000_0000, 1'b0, 7, 2'b01, 18'h00007};
    vecs[13] = '{1'b0, 4'hF, 32'h0000_000C, 32'h0,        32'haa07_5add, 1'b0, 5, 2'b00, 18'h00007};
    vecs[14] = '{1'b1, 4'hF, 32'h0007_FFFC, 32'h0badf00d, 32'h0000_0000, 1'b0, 7, 2'b00, 18'h3FFFF};
    vecs[15] = '{1'b0, 4'hF, 32'h0007_FFFC, 32'h0,        32'h0bad_f00d, 1'b0, 5, 2'b00, 18'h3FFFF};
    vecs[16] = '{1'b0, 4'h8, 32'h0007_FFFC, 32'h0,        32'h0b00_0000, 1'b0, 3, 2'b01, 18'h3FFFF};

    midx = '{0, 1, 2, 3, 4, 5, 6, 7, 254, 255};
    mexp = '{16'hbeef, 16'hdead, 16'h5678, 16'h5A03, 16'h5A04, 16'hcafe, 16'h5ADD, 16'hAA07,
             16'hf00d, 16'h0bad};

    rst = 1'b1; cs = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_w = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.strobes", {sram_ce_n, sram_we_n, sram_oe_n}, 3'b111);
    chk("reset.be_n", sram_be_n, 2'b11);
    chk("reset.ack_err_oe", {ack, err, sram_dat_oe}, 3'b000);
    chk("reset.sram_adr", sram_adr, 18'h0);
    chk("reset.sram_dat_w", sram_dat_w, 16'h0);
    chk("reset.dat_r", dat_r, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) run(vecs[i], $sformatf("v%0d", i));

    for (int i = 0; i < 10; i++) chk($sformatf("mem[%0d]", midx[i]), mem[midx[i]], mexp[i]);

    // Reset in the middle of a write sub-access: strobes drop without a clock, no ack follows.
    @(negedge clk);
    cs = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h0; dat_w = 32'h11223344;
    @(posedge clk); #1;
    chk("rst_mid.we_n_active", sram_we_n, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid.strobes", {sram_ce_n, sram_we_n, sram_oe_n, sram_dat_oe}, 4'b1110);
    cs = 1'b0;
    acks = 0;
    repeat (3) begin @(posedge clk); #1; if (ack) acks++; end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; if (ack) acks++; end
    chk("rst_mid.no_ack", acks, 0);
    chk("rst_mid.mem0_untouched", mem[0], 16'hbeef);
    run(vecs[0], "rst_mid.write");
    run(vecs[1], "rst_mid.read");

    // Back-to-back reads with cs held high through the first ack.
    @(negedge clk);
    cs = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h0;
    sb.push_back(vecs[1]);
    sb.push_back(vecs[1]);
    for (int t = 0; t < 2; t++) begin
      vec_t e;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!ack && n < 40);
      e = sb.pop_front();
      chk($sformatf("b2b%0d.lat", t), n, (t == 0) ? 5 : 6);
      chk($sformatf("b2b%0d.dat_r", t), dat_r, e.exp_dat);
    end
    @(negedge clk);
    cs = 1'b0;
    @(posedge clk); #1;
    chk("b2b.ack_pulse", ack, 1'b0);

    // Zero-sel with cs held: ack every other cycle, SRAM never strobed.
    @(negedge clk);
    cs = 1'b1; sel = 4'h0; n = ce_total;
    for (int t = 0; t < 6; t++) begin @(posedge clk); #1; pat[5-t] = ack; end
    @(negedge clk);
    cs = 1'b0;
    chk("zsel_b2b.ack_pattern", pat, 6'b101010);
    chk("zsel_b2b.ce_cycles", ce_total - n, 0);
    chk("zsel_b2b.dat_r", dat_r, 32'h0);

    repeat (2) @(posedge clk);
    chk("protocol.violations", viol, 0);
    chk("scoreboard.empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
